// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared definitions for the neuron evaluation sequencer:
//                FSM state encoding and default datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Default operand width (products and accumulator are twice this)
    localparam int c_n_default     = 18;
    // Default width of the pair-count input
    localparam int c_len_w_default = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ACC  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/mac_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mac_acc
//  Description : Signed N x N multiply feeding a 2N-bit wrapping accumulator.
//                clr has priority over en. Only the upper half of the
//                accumulator leaves the block; that is all the ReLU/quantize
//                decode needs.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr           - zero the accumulator
//                en            - add w_in*x_in into the accumulator
//                w_in, x_in    - signed N-bit operands
//                acc_hi        - acc[2N-1:N]
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_acc #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] w_in,
    input  logic [N-1:0] x_in,
    output logic [N-1:0] acc_hi
);

    logic [2*N-1:0] w_w_ext;
    logic [2*N-1:0] w_x_ext;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_acc_d;
    logic [2*N-1:0] r_acc_q;

    // Sign-extend to 2N so the low 2N bits of the product are the exact
    // signed product (it always fits in 2N bits).
    assign w_w_ext = {{N{w_in[N-1]}}, w_in};
    assign w_x_ext = {{N{x_in[N-1]}}, x_in};
    assign w_prod  = w_w_ext * w_x_ext;

    always_comb begin
        w_acc_d = r_acc_q;
        if (clr) begin
            w_acc_d = '0;
        end else if (en) begin
            // Two's complement wrap modulo 2^2N, no saturation
            w_acc_d = r_acc_q + w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q <= '0;
        end else begin
            r_acc_q <= w_acc_d;
        end
    end

    assign acc_hi = r_acc_q[2*N-1:N];

endmodule : mac_acc
`default_nettype wire

// File: rtl/neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_seq
//  Description : Sequencer for a single neuron evaluation. On start it clears
//                the accumulator, accepts exactly len weight/activation pairs
//                over a valid/ready stream, then presents ReLU(acc) quantized
//                to the upper N bits on an output valid/ready port.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                start, len            - launch an evaluation (IDLE only)
//                busy                  - state is not IDLE
//                in_valid, in_ready    - operand stream handshake
//                w_in, x_in            - signed weight / activation
//                out_valid, out_ready  - result handshake
//                out_data              - ReLU output, acc[2N-1:N] or 0
//                out_neg               - sign of the final accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int N     = c_n_default,
    parameter int LEN_W = c_len_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     w_in,
    input  logic [N-1:0]     x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_neg
);

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    state_t           r_state_q;
    state_t           w_state_d;
    logic [LEN_W-1:0] r_rem_q;
    logic [LEN_W-1:0] w_rem_d;
    logic             r_busy_q;
    logic             r_in_ready_q;
    logic             r_out_valid_q;
    logic             w_busy_d;
    logic             w_in_ready_d;
    logic             w_out_valid_d;
    logic             w_accept;
    logic             w_clr;
    logic [N-1:0]     w_acc_hi;

    // in_ready is a registered decode of ACC, so it is a safe handshake term
    assign w_accept = in_valid & r_in_ready_q;

    always_comb begin
        w_state_d = r_state_q;
        w_rem_d   = r_rem_q;
        w_clr     = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_clr = 1'b1;
                    if (len != '0) begin
                        w_state_d = S_ACC;
                        w_rem_d   = len;
                    end else begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    w_rem_d = r_rem_q - c_one;
                    if (r_rem_q == c_one) begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start coinciding with the handshake is not looked at
                // here, which forces one IDLE cycle between evaluations.
                if (r_out_valid_q && out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_rem_d   = '0;
            end
        endcase

        // Status outputs are decoded from the next state and registered so
        // they line up exactly with the state they describe.
        w_busy_d      = (w_state_d != S_IDLE);
        w_in_ready_d  = (w_state_d == S_ACC);
        w_out_valid_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_rem_q       <= '0;
            r_busy_q      <= 1'b0;
            r_in_ready_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_rem_q       <= w_rem_d;
            r_busy_q      <= w_busy_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    mac_acc #(
        .N (N)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_accept),
        .w_in   (w_in),
        .x_in   (x_in),
        .acc_hi (w_acc_hi)
    );

    assign busy      = r_busy_q;
    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;

    // ReLU looks only at the sign bit; quantization is the upper half
    assign out_neg   = w_acc_hi[N-1];
    assign out_data  = w_acc_hi[N-1] ? '0 : w_acc_hi;

endmodule : neuron_seq
`default_nettype wire

// File: tb/tb_neuron_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_seq
//  Description : Self-checking bench for neuron_seq. Directed scenarios plus
//                randomized evaluations compared against a plain-arithmetic
//                dot-product / ReLU / quantize reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_seq;

    localparam int N     = 18;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     w_in;
    logic [N-1:0]     x_in;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_neg;

    int n_checks = 0;
    int n_fail   = 0;

    int wv   [256];
    int xv   [256];
    int vpat [256];
    int vpat_len;

    always #5 clk = ~clk;

    neuron_seq #(
        .N     (N),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_in      (w_in),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
    );

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rand_s18();
        int r;
        r = int'($urandom % 262144);
        if (r >= 131072) r -= 262144;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, ".busy"},      64'(busy),      64'd0);
        check_value({tag, ".in_ready"},  64'(in_ready),  64'd0);
        check_value({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    endtask

    // valid_mode: 0 = in_valid held high, 1 = random, 2 = from vpat
    task automatic run_eval(input string tag, input int n, input int valid_mode,
                            input int stall_out);
        longint      sum;
        logic [63:0] s64;
        logic [35:0] e;
        logic [17:0] exp_data;
        logic [17:0] held;
        int          idx;
        int          cyc;
        int          pcnt;
        bit          v;

        sum  = 0;
        idx  = 0;
        pcnt = 0;
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        cyc = 1;

        while (idx < n) begin
            check_value({tag, ".acc_in_ready"}, 64'(in_ready), 64'd1);
            check_value({tag, ".acc_busy"},     64'(busy),     64'd1);
            check_value({tag, ".acc_out_valid"},64'(out_valid),64'd0);
            if (valid_mode == 0)      v = 1'b1;
            else if (valid_mode == 1) v = 1'($urandom_range(0, 1));
            else                      v = (pcnt < vpat_len) ? (vpat[pcnt] != 0) : 1'b1;
            pcnt++;
            in_valid = v;
            w_in     = N'(wv[idx]);
            x_in     = N'(xv[idx]);
            // start during ACC must be ignored
            start    = 1'($urandom_range(0, 1));
            len      = LEN_W'($urandom_range(0, 255));
            tick();
            cyc++;
            if (v) begin
                sum += longint'(wv[idx]) * longint'(xv[idx]);
                idx++;
            end
            if (cyc > 2000) begin
                check_value({tag, ".acc_timeout"}, 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;

        s64      = 64'(sum);
        e        = s64[35:0];
        exp_data = e[35] ? 18'd0 : e[35:18];

        if (valid_mode == 0)
            check_value({tag, ".latency"}, 64'(cyc), 64'(n + 1));
        check_value({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check_value({tag, ".in_ready"},  64'(in_ready),  64'd0);
        check_value({tag, ".busy"},      64'(busy),      64'd1);
        check_value({tag, ".acc"},       64'(dut.u_mac.r_acc_q), 64'(e));
        check_value({tag, ".out_data"},  64'(out_data),  64'(exp_data));
        check_value({tag, ".out_neg"},   64'(out_neg),   64'(e[35]));

        held = out_data;
        for (int i = 0; i < stall_out; i++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            tick();
            check_value({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check_value({tag, ".stall_busy"},  64'(busy),      64'd1);
            check_value({tag, ".stall_data"},  64'(out_data),  64'(held));
        end
        // start coincident with the handshake must not launch a new run
        out_ready = 1'b1;
        start     = 1'b1;
        len       = LEN_W'(3);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check_idle({tag, ".post"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        w_in = '0; x_in = '0; out_ready = 1'b0;
        vpat_len = 0;
        tick(); tick();
        check_idle("reset");
        check_value("reset.out_data", 64'(out_data), 64'd0);
        check_value("reset.out_neg",  64'(out_neg),  64'd0);
        rst = 1'b0;
        tick();

        // Basic dot product: 6 - 4 + 5 = 7
        wv[0] = 2;  xv[0] = 3;
        wv[1] = -1; xv[1] = 4;
        wv[2] = 5;  xv[2] = 1;
        run_eval("basic", 3, 0, 0);

        // Large positive result: 2^32 -> out_data 2^14
        wv[0] = 65536; xv[0] = 65536;
        run_eval("large", 1, 0, 1);
        check_value("large.final_data_const", 64'(dut.u_mac.r_acc_q), 64'h1_0000_0000);

        // Negative result clamps
        wv[0] = -3; xv[0] = 5;
        wv[1] = 1;  xv[1] = 2;
        run_eval("neg", 2, 0, 0);

        // Back-pressure pattern with output stall
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
        vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
        vpat_len = 7;
        for (int i = 0; i < 4; i++) begin
            wv[i] = rand_s18(); xv[i] = rand_s18();
        end
        run_eval("bp", 4, 2, 5);

        // len = 0
        run_eval("len0", 0, 0, 0);

        // Wrap: 2 * 2^34 = 2^35 -> negative in 36 bits
        wv[0] = -131072; xv[0] = -131072;
        wv[1] = -131072; xv[1] = -131072;
        run_eval("wrap", 2, 0, 0);

        // Reset mid-ACC after 2 of 5 pairs
        start = 1'b1; len = LEN_W'(5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            w_in = N'(100 + i); x_in = N'(7);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_idle("rst_mid");
        check_value("rst_mid.out_data", 64'(out_data), 64'd0);
        check_value("rst_mid.out_neg",  64'(out_neg),  64'd0);
        check_value("rst_mid.acc",      64'(dut.u_mac.r_acc_q), 64'd0);
        rst = 1'b0;
        tick();
        wv[0] = 3; xv[0] = 3;
        run_eval("after_rst", 1, 0, 0);

        // Randomized evaluations
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                wv[i] = rand_s18(); xv[i] = rand_s18();
            end
            run_eval($sformatf("rand%0d", t), n, $urandom_range(0, 1),
                     $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_neuron_seq
`default_nettype wire
